// File: rtl/bcd_scan_display_if.sv
// ---------------------------------------------------------------------------
// bcd_scan_display_if
//   Bundles the digit-load bus and the display outputs of bcd_scan_display.
//   Optional feature macro affecting the attached driver: BCD_SCAN_LZB_EN.
//   Signals:
//     load        : capture hundreds/tens/ones into staging (source -> driver)
//     hundreds    : BCD hundreds digit
//     tens        : BCD tens digit
//     ones        : BCD ones digit
//     seg         : segment drive {g,f,e,d,c,b,a}, active high (driver -> sink)
//     an          : one-hot digit enable, an[0]=ones, an[1]=tens, an[2]=hundreds
//     frame_done  : one-cycle pulse after each completed 3-digit frame
//   Modports: master = digit source / display observer, slave = the driver.
// ---------------------------------------------------------------------------
interface bcd_scan_display_if;
    logic       load;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame_done;

    modport master (
        output load,
        output hundreds,
        output tens,
        output ones,
        input  seg,
        input  an,
        input  frame_done
    );

    modport slave (
        input  load,
        input  hundreds,
        input  tens,
        input  ones,
        output seg,
        output an,
        output frame_done
    );
endinterface

// File: rtl/bcd_scan_display.sv
// ---------------------------------------------------------------------------
// bcd_scan_display
//   Time-multiplexed 3-digit seven-segment driver. Digits are captured into
//   staging registers on load and copied to the active set only at frame
//   start, so a frame never shows a half-updated number.
//   Optional feature: define BCD_SCAN_LZB_EN for leading-zero blanking of the
//   hundreds and tens digits (ones are never blanked).
//   Parameters:
//     CLK_DIV : clock cycles each digit is shown (2..2^20)
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-high reset
//     bus : bcd_scan_display_if.slave (load/hundreds/tens/ones in,
//           seg/an/frame_done out, all outputs registered)
// ---------------------------------------------------------------------------
module bcd_scan_display #(
    parameter int unsigned CLK_DIV = 50000
) (
    input logic                     clk,
    input logic                     rst,
    bcd_scan_display_if.slave       bus
);
    localparam int unsigned     CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    typedef enum logic [1:0] {StBlank, StOnes, StTens, StHund} state_e;

    state_e          r_state;
    state_e          w_state_next;
    logic [CntW-1:0] r_cnt;
    logic            w_tick;
    logic            w_frame_start;
    logic [3:0]      r_stg_h, r_stg_t, r_stg_o;
    logic [3:0]      r_act_h, r_act_t, r_act_o;
    logic [6:0]      r_seg, w_seg_next;
    logic [2:0]      r_an, w_an_next;
    logic            r_frame_done, w_frame_done_next;

    function automatic logic [6:0] f_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h40;  // dash for non-BCD input
        endcase
        return seg;
    endfunction

    assign w_tick = (r_cnt == CntMax);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StBlank;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state plus the output values for the state being entered.
    always_comb begin
        w_state_next      = r_state;
        w_frame_start     = 1'b0;
        w_an_next         = r_an;
        w_seg_next        = r_seg;
        w_frame_done_next = 1'b0;
        if (w_tick) begin
            unique case (r_state)
                StBlank, StHund: begin
                    w_state_next      = StOnes;
                    w_frame_start     = 1'b1;
                    w_an_next         = 3'b001;
                    // Active ones register loads on this same edge, so use staging.
                    w_seg_next        = f_encode(r_stg_o);
                    w_frame_done_next = (r_state == StHund);
                end
                StOnes: begin
                    w_state_next = StTens;
                    w_an_next    = 3'b010;
                    w_seg_next   = f_encode(r_act_t);
`ifdef BCD_SCAN_LZB_EN
                    if (r_act_h == 4'd0 && r_act_t == 4'd0) begin
                        w_seg_next = 7'h00;
                    end
`endif
                end
                StTens: begin
                    w_state_next = StHund;
                    w_an_next    = 3'b100;
                    w_seg_next   = f_encode(r_act_h);
`ifdef BCD_SCAN_LZB_EN
                    if (r_act_h == 4'd0) begin
                        w_seg_next = 7'h00;
                    end
`endif
                end
                default: begin
                    w_state_next = StBlank;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stg_h <= 4'd0;
            r_stg_t <= 4'd0;
            r_stg_o <= 4'd0;
        end else if (bus.load) begin
            r_stg_h <= bus.hundreds;
            r_stg_t <= bus.tens;
            r_stg_o <= bus.ones;
        end
    end

    // A load coinciding with frame start is not seen here until the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_h <= 4'd0;
            r_act_t <= 4'd0;
            r_act_o <= 4'd0;
        end else if (w_frame_start) begin
            r_act_h <= r_stg_h;
            r_act_t <= r_stg_t;
            r_act_o <= r_stg_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= 3'b000;
            r_seg        <= 7'h00;
            r_frame_done <= 1'b0;
        end else begin
            r_an         <= w_an_next;
            r_seg        <= w_seg_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.frame_done = r_frame_done;

    // act_o mirrors what was latched for the ones digit; kept for observability.
    logic w_unused;
    assign w_unused = ^r_act_o;
endmodule

// File: tb/tb_bcd_scan_display.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_display
//   Directed bench for bcd_scan_display with CLK_DIV=4. Expected display
//   states are queued when stimulus is applied and popped at check points.
//   Honours BCD_SCAN_LZB_EN for the blanking expectations.
// ---------------------------------------------------------------------------
module tb_bcd_scan_display;
    localparam int unsigned ClkDiv = 4;
`ifdef BCD_SCAN_LZB_EN
    localparam logic [6:0] LeadZero = 7'h00;
`else
    localparam logic [6:0] LeadZero = 7'h3F;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    logic [10:0] exp_q[$];  // {an[2:0], seg[6:0], frame_done}
    string       tag_q[$];

    always #5 clk = ~clk;

    bcd_scan_display_if bus_if ();

    bcd_scan_display #(
        .CLK_DIV (ClkDiv)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [2:0] an, input logic [6:0] seg,
                        input logic fd);
        exp_q.push_back({an, seg, fd});
        tag_q.push_back(tag);
    endtask

    task automatic load(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        bus_if.load     = 1'b1;
        bus_if.hundreds = h;
        bus_if.tens     = t;
        bus_if.ones     = o;
    endtask

    task automatic chk();
        logic [10:0] e;
        string       tag;
        n_chk++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: got empty queue, expected an entry");
            return;
        end
        e   = exp_q.pop_front();
        tag = tag_q.pop_front();
        assert (bus_if.an === e[10:8]) else begin
            n_err++;
            $error("FAIL %s.an: got %b expected %b", tag, bus_if.an, e[10:8]);
        end
        n_chk++;
        assert (bus_if.seg === e[7:1]) else begin
            n_err++;
            $error("FAIL %s.seg: got %h expected %h", tag, bus_if.seg, e[7:1]);
        end
        n_chk++;
        assert (bus_if.frame_done === e[0]) else begin
            n_err++;
            $error("FAIL %s.frame_done: got %b expected %b", tag, bus_if.frame_done, e[0]);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.load     = 1'b0;
        bus_if.hundreds = 4'd0;
        bus_if.tens     = 4'd0;
        bus_if.ones     = 4'd0;

        // Reset state
        push("reset", 3'b000, 7'h00, 1'b0);
        tick_n(2);
        chk();

        // Release and load 255 before the first tick
        rst = 1'b0;
        load(4'd2, 4'd5, 4'd5);
        push("e3_blank", 3'b000, 7'h00, 1'b0);
        push("e4_ones", 3'b001, 7'h6D, 1'b0);
        push("e8_tens", 3'b010, 7'h6D, 1'b0);
        push("e12_hund", 3'b100, 7'h5B, 1'b0);
        push("e16_ones", 3'b001, 7'h6D, 1'b1);
        push("e17_fd_drop", 3'b001, 7'h6D, 1'b0);
        push("e20_tens", 3'b010, 7'h6D, 1'b0);
        tick_n(1);
        bus_if.load = 1'b0;
        tick_n(2);
        chk();
        tick_n(1);
        chk();
        tick_n(4);
        chk();
        tick_n(4);
        chk();
        tick_n(4);
        chk();
        tick_n(1);
        chk();
        tick_n(3);
        chk();

        // No tearing: load 138 during TENS of the 255 frame
        load(4'd1, 4'd3, 4'd8);
        push("tear_hund", 3'b100, 7'h5B, 1'b0);
        push("tear_ones", 3'b001, 7'h7F, 1'b1);
        push("tear_tens", 3'b010, 7'h4F, 1'b0);
        push("tear_hund2", 3'b100, 7'h06, 1'b0);
        tick_n(1);
        bus_if.load = 1'b0;
        tick_n(3);
        chk();
        tick_n(4);
        chk();
        tick_n(4);
        chk();
        tick_n(4);
        chk();

        // Load coincident with HUND->ONES edge (E40)
        tick_n(3);
        load(4'd9, 4'd9, 4'd9);
        push("coin_ones_old", 3'b001, 7'h7F, 1'b1);
        push("coin_tens_old", 3'b010, 7'h4F, 1'b0);
        push("coin_hund_old", 3'b100, 7'h06, 1'b0);
        push("coin_ones_new", 3'b001, 7'h6F, 1'b1);
        push("coin_tens_new", 3'b010, 7'h6F, 1'b0);
        push("coin_hund_new", 3'b100, 7'h6F, 1'b0);
        tick_n(1);
        bus_if.load = 1'b0;
        chk();
        for (int i = 0; i < 5; i++) begin
            tick_n(4);
            chk();
        end

        // Invalid BCD in tens
        load(4'd1, 4'hA, 4'd3);
        push("bad_ones", 3'b001, 7'h4F, 1'b1);
        push("bad_tens", 3'b010, 7'h40, 1'b0);
        push("bad_hund", 3'b100, 7'h06, 1'b0);
        tick_n(1);
        bus_if.load = 1'b0;
        tick_n(3);
        chk();
        tick_n(4);
        chk();
        tick_n(4);
        chk();

        // Leading zeros: 007
        load(4'd0, 4'd0, 4'd7);
        push("lz7_ones", 3'b001, 7'h07, 1'b1);
        push("lz7_tens", 3'b010, LeadZero, 1'b0);
        push("lz7_hund", 3'b100, LeadZero, 1'b0);
        tick_n(1);
        bus_if.load = 1'b0;
        tick_n(3);
        chk();
        tick_n(4);
        chk();
        tick_n(4);
        chk();

        // All zeros: ones never blanked
        load(4'd0, 4'd0, 4'd0);
        push("lz0_ones", 3'b001, 7'h3F, 1'b1);
        push("lz0_tens", 3'b010, LeadZero, 1'b0);
        tick_n(1);
        bus_if.load = 1'b0;
        tick_n(3);
        chk();
        tick_n(4);
        chk();

        // Reset mid-TENS (staging holds 999 to prove it is cleared)
        load(4'd9, 4'd9, 4'd9);
        tick_n(1);
        bus_if.load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        push("rst_async", 3'b000, 7'h00, 1'b0);
        chk();
        push("rst_hold", 3'b000, 7'h00, 1'b0);
        push("rst_e3_blank", 3'b000, 7'h00, 1'b0);
        push("rst_e4_ones", 3'b001, 7'h3F, 1'b0);
        tick_n(2);
        chk();
        rst = 1'b0;
        tick_n(3);
        chk();
        tick_n(1);
        chk();

        n_chk++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: got %0d left, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
